// File: rtl/pwm_pkg.sv
// Shared PWM definitions: timing defaults used by both the dimmer/PWM
// generator and this decoder, FSM state type, and the published result.
package pwm_pkg;

  // Transmitter and receiver must agree on these.
  localparam int unsigned PWM_STEP_CYCLES      = 1200;
  localparam int unsigned PWM_STEPS_PER_PERIOD = 250;
  localparam int unsigned PWM_TIMEOUT_PERIODS  = 2;

  // Step counter width; saturates at all-ones.
  localparam int unsigned STEP_CNT_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_HIGH      = 2'd2,
    ST_LOW       = 2'd3
  } pwm_state_e;

  // Registered decoder outputs, kept together so they update as one.
  typedef struct packed {
    logic [7:0] duty;
    logic       valid;
    logic       static_lvl;
    logic       period_err;
  } pwm_meas_t;

  // Bits needed to hold 0..value-1 (at least 1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 1) ? value - 1 : 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_duty_decoder_sync_edge_detect.sv
// 2-FF synchronizer per lane plus one delay register for edge detection.
// rise/fall are single-cycle pulses derived from the synchronized level.
module sync_edge_detect #(
  parameter int unsigned NUM_LANES = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_LANES-1:0] async_in,
  output logic [NUM_LANES-1:0] level,
  output logic [NUM_LANES-1:0] rise,
  output logic [NUM_LANES-1:0] fall
);

  logic [NUM_LANES-1:0] meta_q, meta_d;
  logic [NUM_LANES-1:0] sync_q, sync_d;
  logic [NUM_LANES-1:0] dly_q,  dly_d;

  // Shift chain: async -> meta -> sync -> dly
  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  // Chain registers, cleared so no edge is seen out of reset with input low
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
      dly_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~dly_q;
  assign fall  = ~sync_q & dly_q;

endmodule

// File: rtl/pwm_duty_decoder.sv
// Recovers the 8-bit duty of an incoming PWM waveform by timing high
// time and period in transmitter steps. Also flags static input levels
// (no edges for a timeout) and periods that are off-nominal.
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int unsigned STEP_CYCLES      = PWM_STEP_CYCLES,
  parameter int unsigned STEPS_PER_PERIOD = PWM_STEPS_PER_PERIOD,
  parameter int unsigned TIMEOUT_PERIODS  = PWM_TIMEOUT_PERIODS
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pwm_in,
  input  logic       enable,
  output logic [7:0] duty,
  output logic       duty_valid,
  output logic       static_level,
  output logic       period_error
);

  localparam int unsigned PRE_W = clog2(STEP_CYCLES);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(STEP_CYCLES - 1);
  // The edge cycle itself is part of the measured interval, so the
  // elapsed count is prescaler+1; round half up on that.
  localparam logic [PRE_W-1:0] PRE_RND = PRE_W'(STEP_CYCLES / 2 - 1);

  localparam logic [STEP_CNT_W-1:0] STEP_MAX = '1;
  localparam logic [STEP_CNT_W-1:0] SPP      = STEP_CNT_W'(STEPS_PER_PERIOD);
  localparam logic [STEP_CNT_W-1:0] SPP_LO   = STEP_CNT_W'(STEPS_PER_PERIOD - 1);
  localparam logic [STEP_CNT_W-1:0] SPP_HI   = STEP_CNT_W'(STEPS_PER_PERIOD + 1);
  localparam int unsigned            TO_RAW   = TIMEOUT_PERIODS * STEPS_PER_PERIOD;
  localparam logic [STEP_CNT_W-1:0] TO_STEPS =
    (TO_RAW > 511) ? STEP_MAX : STEP_CNT_W'(TO_RAW);
  localparam logic [7:0]            DUTY_FULL = 8'(STEPS_PER_PERIOD);

  // Synchronized input
  logic pwm_lvl, pwm_rise, pwm_fall, pwm_edge;

  sync_edge_detect #(.NUM_LANES(1)) u_sync (
    .clock    (clock),
    .reset_n  (reset_n),
    .async_in (pwm_in),
    .level    (pwm_lvl),
    .rise     (pwm_rise),
    .fall     (pwm_fall)
  );

  assign pwm_edge = pwm_rise | pwm_fall;

  // State
  pwm_state_e              state_q, state_d;
  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [STEP_CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic [STEP_CNT_W-1:0]   high_q, high_d;
  pwm_meas_t               meas_q, meas_d;

  // Derived terms
  logic [STEP_CNT_W-1:0]   rnd_steps;
  logic                    timeout;
  logic                    period_ok;
  logic [7:0]              to_duty;
  logic                    to_pulse;

  // Rounded step count, timeout and static-level result
  always_comb begin
    rnd_steps = step_cnt_q;
    if (presc_q >= PRE_RND && step_cnt_q != STEP_MAX)
      rnd_steps = step_cnt_q + 1'b1;
    period_ok = (rnd_steps >= SPP_LO) && (rnd_steps <= SPP_HI);
    timeout   = (step_cnt_q >= TO_STEPS);
    to_duty   = pwm_lvl ? DUTY_FULL : 8'd0;
    // Repeated timeouts while static only report a changed level.
    to_pulse  = !meas_q.static_lvl || (meas_q.duty != to_duty);
  end

  // Timebase and measurement FSM
  always_comb begin
    state_d          = state_q;
    presc_d          = presc_q;
    step_cnt_d       = step_cnt_q;
    high_d           = high_q;
    meas_d           = meas_q;
    meas_d.valid     = 1'b0;

    if (!enable) begin
      state_d    = ST_IDLE;
      presc_d    = '0;
      step_cnt_d = '0;
      high_d     = '0;
    end else begin
      // Prescaler/step counter run in every measuring state.
      if (state_q != ST_IDLE) begin
        if (presc_q == PRE_MAX) begin
          presc_d = '0;
          if (step_cnt_q != STEP_MAX)
            step_cnt_d = step_cnt_q + 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
        if (pwm_edge) presc_d    = '0;
        if (pwm_rise) step_cnt_d = '0;
      end

      case (state_q)
        ST_IDLE: state_d = ST_WAIT_RISE;

        // First period after start is partial: just synchronize.
        ST_WAIT_RISE: begin
          if (pwm_rise) begin
            state_d = ST_HIGH;
          end else if (timeout) begin
            meas_d.static_lvl = 1'b1;
            meas_d.duty       = to_duty;
            meas_d.valid      = to_pulse;
            step_cnt_d        = '0;
          end
        end

        ST_HIGH: begin
          if (pwm_fall) begin
            high_d  = rnd_steps;
            state_d = ST_LOW;
          end else if (timeout) begin
            meas_d.static_lvl = 1'b1;
            meas_d.duty       = to_duty;
            meas_d.valid      = to_pulse;
            step_cnt_d        = '0;
            state_d           = ST_WAIT_RISE;
          end
        end

        ST_LOW: begin
          if (pwm_rise) begin
            if (period_ok) begin
              meas_d.duty       = 8'((high_q > SPP) ? SPP : high_q);
              meas_d.valid      = 1'b1;
              meas_d.period_err = 1'b0;
              meas_d.static_lvl = 1'b0;
            end else begin
              meas_d.period_err = 1'b1;
            end
            state_d = ST_HIGH;
          end else if (timeout) begin
            meas_d.static_lvl = 1'b1;
            meas_d.duty       = to_duty;
            meas_d.valid      = to_pulse;
            step_cnt_d        = '0;
            state_d           = ST_WAIT_RISE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      step_cnt_q <= '0;
      high_q     <= '0;
      meas_q     <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      step_cnt_q <= step_cnt_d;
      high_q     <= high_d;
      meas_q     <= meas_d;
    end
  end

  assign duty         = meas_q.duty;
  assign duty_valid   = meas_q.valid;
  assign static_level = meas_q.static_lvl;
  assign period_error = meas_q.period_err;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed + randomized bench for pwm_duty_decoder. A waveform-level model
// turns each driven segment into expected publishes using clock counts.
module tb_pwm_duty_decoder;

  localparam int SC     = 4;      // clocks per step
  localparam int SPP    = 250;    // steps per period
  localparam int TO_CLK = 2 * SPP * SC;

  logic       clock = 1'b0;
  logic       rst_n = 1'b1;
  logic       pwm_in = 1'b0;
  logic       en = 1'b1;
  logic [7:0] duty;
  logic       duty_valid, static_level, period_error;

  int checks = 0;
  int failures = 0;

  pwm_duty_decoder #(
    .STEP_CYCLES      (SC),
    .STEPS_PER_PERIOD (SPP),
    .TIMEOUT_PERIODS  (2)
  ) dut (
    .clock        (clock),
    .reset_n      (rst_n),
    .pwm_in       (pwm_in),
    .enable       (en),
    .duty         (duty),
    .duty_valid   (duty_valid),
    .static_level (static_level),
    .period_error (period_error)
  );

  always #5 clock = ~clock;

  // Observed publishes
  int got_q[$];
  always @(negedge clock)
    if (rst_n && duty_valid) got_q.push_back(int'(duty));

  // Reference model state (times in clocks)
  int now = 0, t_rise = 0, t_fall = 0, origin = 0;
  bit have_ref = 0, seen = 0, m_static = 0, m_err = 0;
  int m_duty = 0;
  int exp_q[$];

  // A rise closes a period if a reference rise exists.
  function automatic void m_rise();
    int p, h, rp, d;
    if (have_ref) begin
      p  = now - t_rise;
      h  = t_fall - t_rise;
      rp = (p + SC / 2) / SC;
      if (rp >= SPP - 1 && rp <= SPP + 1) begin
        d = (h + SC / 2) / SC;
        if (d > SPP) d = SPP;
        m_duty = d; m_err = 0; m_static = 0;
        exp_q.push_back(d);
      end else begin
        m_err = 1;
      end
    end
    have_ref = 1; t_rise = now; origin = now;
  endfunction

  // Edge-free stretches: static declared every TO_CLK from the last origin.
  function automatic void m_timeouts(input bit lvl, input int t_end);
    int nd;
    while (origin + TO_CLK <= t_end) begin
      nd = lvl ? SPP : 0;
      if (!m_static || m_duty != nd) exp_q.push_back(nd);
      m_static = 1; m_duty = nd; have_ref = 0;
      origin += TO_CLK;
    end
  endfunction

  function automatic void m_reset();
    m_duty = 0; m_static = 0; m_err = 0; have_ref = 0; seen = 0;
  endfunction

  task automatic drive(input bit lvl, input int n);
    pwm_in = lvl;
    if (lvl != seen) begin
      seen = lvl;
      if (lvl) begin if (en) m_rise(); end
      else t_fall = now;
    end
    if (en) m_timeouts(lvl, now + n);
    repeat (n) @(negedge clock);
    now += n;
  endtask

  task automatic period(input int h, input int p);
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".npub"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, ".pub"}, got_q[i], exp_q[i]);
    chk({tag, ".duty"},   {24'd0, duty},   m_duty);
    chk({tag, ".static"}, {31'd0, static_level}, {31'd0, m_static});
    chk({tag, ".perr"},   {31'd0, period_error}, {31'd0, m_err});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".duty"},   {24'd0, duty}, 0);
    chk({tag, ".valid"},  {31'd0, duty_valid}, 0);
    chk({tag, ".static"}, {31'd0, static_level}, 0);
    chk({tag, ".perr"},   {31'd0, period_error}, 0);
  endtask

  int sweep_tab[9] = '{1, 2, 3, 50, 125, 200, 247, 248, 249};

  initial begin
    // Power-on reset
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clock);
    check_zero("reset");
    rst_n = 1'b1;
    m_reset();
    origin = now;

    // Steady 100/250
    drive(1'b0, 100);
    repeat (3) period(400, 1000);
    check_state("steady");

    // Duty sweep points plus random high times
    foreach (sweep_tab[i]) period(sweep_tab[i] * SC, 1000);
    check_state("sweep");
    for (int i = 0; i < 12; i++) period($urandom_range(4, 996), 1000);
    check_state("random");

    // Static low, then static high
    drive(1'b0, 2000);
    check_state("static_lo");
    drive(1'b1, 2500);
    check_state("static_hi");

    // Off-nominal period, recovery, 251-step tolerance
    drive(1'b0, 600);
    period(400, 1000);
    period(480, 960);
    period(480, 1000);
    check_state("perr_240");
    period(400, 1004);
    check_state("perr_clear");
    period(400, 1000);
    check_state("p251_ok");

    // Half-step rounding
    period(402, 1000);
    period(401, 1000);
    period(400, 1000);
    check_state("jitter");

    // Async reset in the middle of a high phase
    drive(1'b1, 200);
    check_state("pre_rst");
    #2 rst_n = 1'b0;
    m_reset();
    #1 check_zero("rst_async");
    repeat (5) @(negedge clock);
    now += 5;
    rst_n = 1'b1;
    origin = now;
    if (pwm_in) begin seen = 1; m_rise(); end
    drive(1'b1, 195);
    drive(1'b0, 600);
    period(400, 1000);
    period(400, 1000);
    check_state("post_rst");

    // Enable dropped mid-low
    drive(1'b1, 400);
    drive(1'b0, 300);
    en = 1'b0;
    have_ref = 0;
    drive(1'b0, 10);
    check_state("en_off");
    en = 1'b1;
    origin = now;
    drive(1'b0, 290);
    period(300, 1000);
    period(300, 1000);
    drive(1'b1, 20);
    check_state("en_on");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
